serial_adder: RTL



---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_fa_cell.sv | 13 +
 rtl/serial_adder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must hold 0..w-1.
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit combinational full adder used for each bit-serial step.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one bit pair per cycle, LSB first, through a single fa_cell.
// Define SERIAL_ADDER_CIN_EN to add a Cin port that seeds the initial carry.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_CIN_EN
    input  logic             Cin,
`endif
    output logic             busy,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cin_init;
    logic               fa_s;
    logic               fa_cout;
    logic               last_bit;

`ifdef SERIAL_ADDER_CIN_EN
    assign cin_init = Cin;
`else
    assign cin_init = 1'b0;
`endif

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    fa_cell u_fa (
        .a   (a_q[0]),
        .b   (b_q[0]),
        .cin (carry_q),
        .s   (fa_s),
        .cout(fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == SHIFT) || (state_q == DONE);
        done = (state_q == DONE);
    end

    // Sum bits enter S from the MSB side so after WIDTH shifts bit 0 sits at S[0];
    // Cout is only committed on the last bit so it holds its value while idle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = cin_init;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                s_d     = {fa_s, s_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) cout_d = fa_cout;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;

endmodule
